// File: rtl/axil2apb_pkg.sv
// Shared types and constants for the AXI4-Lite to APB3 CSB bridge.
package axil2apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_t;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/axil_req_holder.sv
// One-entry request holder for an AXI4-Lite request channel. The output view
// bypasses the incoming beat, so a request can be acted on in its accept cycle.
module axil_req_holder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             avail,
  output logic [WIDTH-1:0] data
);

  logic             full_q;
  logic [WIDTH-1:0] data_q;
  logic             fire;

  // Handshake and the effective (held or in-flight) request view.
  always_comb begin
    in_ready = en && !full_q;
    fire     = in_valid && in_ready;
    avail    = full_q || fire;
    data     = full_q ? data_q : in_data;
  end

  // Holder occupancy: filled on accept, freed by the owner's response handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (clear) full_q <= 1'b0;
      if (fire) begin
        full_q <= 1'b1;
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/axil2apb_csb_bridge.sv
// AXI4-Lite slave to APB3 master bridge for the NVDLA CSB port. One APB
// transfer at a time, read/write alternation on contention, PREADY timeout.
module axil2apb_csb_bridge
  import axil2apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    csb_clk,
  input  logic                    csb_rstn,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  output logic [1:0]              s_axil_bresp,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic [DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned W_WIDTH    = DATA_WIDTH + STRB_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  state_t state_q, state_d;

  logic                  live_q;       // low until the first clock after reset
  logic                  ptr_wr_q;     // next contest goes to write when set
  logic                  cur_write_q;
  logic                  strb_err_q;
  logic [1:0]            resp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  pwrite_q;
  logic [31:0]           tmo_cnt_q;

  logic                  serving_write;
  logic                  aw_avail, w_avail, ar_avail;
  logic [ADDR_WIDTH-1:0] aw_data, ar_data;
  logic [W_WIDTH-1:0]    w_data;
  logic                  start, start_write, done, abort;
  logic                  clear_wr, clear_rd;

  assign serving_write = (state_q != StIdle) && cur_write_q;
  assign clear_wr      = s_axil_bvalid && s_axil_bready;
  assign clear_rd      = s_axil_rvalid && s_axil_rready;

  axil_req_holder #(.WIDTH(ADDR_WIDTH)) u_aw_holder (
    .clk      (csb_clk),
    .rstn     (csb_rstn),
    .en       (live_q && !serving_write),
    .in_valid (s_axil_awvalid),
    .in_ready (s_axil_awready),
    .in_data  (s_axil_awaddr),
    .clear    (clear_wr),
    .avail    (aw_avail),
    .data     (aw_data)
  );

  axil_req_holder #(.WIDTH(W_WIDTH)) u_w_holder (
    .clk      (csb_clk),
    .rstn     (csb_rstn),
    .en       (live_q && !serving_write),
    .in_valid (s_axil_wvalid),
    .in_ready (s_axil_wready),
    .in_data  ({s_axil_wstrb, s_axil_wdata}),
    .clear    (clear_wr),
    .avail    (w_avail),
    .data     (w_data)
  );

  axil_req_holder #(.WIDTH(ADDR_WIDTH)) u_ar_holder (
    .clk      (csb_clk),
    .rstn     (csb_rstn),
    .en       (live_q && (state_q == StIdle)),
    .in_valid (s_axil_arvalid),
    .in_ready (s_axil_arready),
    .in_data  (s_axil_araddr),
    .clear    (clear_rd),
    .avail    (ar_avail),
    .data     (ar_data)
  );

  // FSM state register.
  always_ff @(posedge csb_clk or negedge csb_rstn) begin
    if (!csb_rstn) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // Arbitration, APB phase control and response valids.
  always_comb begin
    state_d       = state_q;
    psel          = 1'b0;
    penable       = 1'b0;
    s_axil_bvalid = 1'b0;
    s_axil_rvalid = 1'b0;
    start         = 1'b0;
    start_write   = 1'b0;
    done          = 1'b0;
    abort         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (aw_avail && w_avail && (!ar_avail || ptr_wr_q)) begin
          start       = 1'b1;
          start_write = 1'b1;
          state_d     = StSetup;
        end else if (ar_avail) begin
          start   = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        psel    = 1'b1;
        state_d = StAccess;
      end
      StAccess: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          done    = 1'b1;
          state_d = StResp;
        end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1))) begin
          abort   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        s_axil_bvalid = cur_write_q;
        s_axil_rvalid = !cur_write_q;
        if (cur_write_q ? s_axil_bready : s_axil_rready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Transfer launch registers, timeout counter and response capture.
  always_ff @(posedge csb_clk or negedge csb_rstn) begin
    if (!csb_rstn) begin
      live_q      <= 1'b0;
      ptr_wr_q    <= 1'b1;
      cur_write_q <= 1'b0;
      strb_err_q  <= 1'b0;
      resp_q      <= RESP_OKAY;
      rdata_q     <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      live_q <= 1'b1;
      if (start) begin
        ptr_wr_q    <= !ptr_wr_q;
        cur_write_q <= start_write;
        pwrite_q    <= start_write;
        paddr_q     <= (start_write ? aw_data : ar_data) & ADDR_MASK;
        // NVDLA has no byte enables: partial strobes still write the full word.
        strb_err_q  <= start_write && (w_data[W_WIDTH-1:DATA_WIDTH] != '1);
        if (start_write) pwdata_q <= w_data[DATA_WIDTH-1:0];
      end
      if (state_q == StSetup)       tmo_cnt_q <= '0;
      else if (state_q == StAccess) tmo_cnt_q <= tmo_cnt_q + 32'd1;
      if (done) begin
        resp_q <= (pslverr || strb_err_q) ? RESP_SLVERR : RESP_OKAY;
        if (!cur_write_q) rdata_q <= prdata;
      end else if (abort) begin
        resp_q <= RESP_SLVERR;
        if (!cur_write_q) rdata_q <= TIMEOUT_RDATA;
      end
    end
  end

  assign pwrite       = pwrite_q;
  assign paddr        = paddr_q;
  assign pwdata       = pwdata_q;
  assign s_axil_bresp = resp_q;
  assign s_axil_rresp = resp_q;
  assign s_axil_rdata = rdata_q;

endmodule

// File: tb/tb_axil2apb_csb_bridge.sv
// Directed bench for axil2apb_csb_bridge with a small APB slave model.
module tb_axil2apb_csb_bridge;

  logic        csb_clk  = 1'b0;
  logic        csb_rstn = 1'b1;
  logic        s_axil_awvalid, s_axil_awready;
  logic [31:0] s_axil_awaddr;
  logic        s_axil_wvalid, s_axil_wready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_bvalid, s_axil_bready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_arvalid, s_axil_arready;
  logic [31:0] s_axil_araddr;
  logic        s_axil_rvalid, s_axil_rready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready = 1'b0;
  logic        pslverr;

  int vectors     = 0;
  int miscompares = 0;
  int wait_states = 0;
  int gap_err     = 0;

  logic [31:0] log_addr[$];
  logic        log_wr[$];
  logic [31:0] log_data[$];

  axil2apb_csb_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .csb_clk        (csb_clk),
    .csb_rstn       (csb_rstn),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .paddr          (paddr),
    .pwdata         (pwdata),
    .prdata         (prdata),
    .pready         (pready),
    .pslverr        (pslverr)
  );

  always #5 csb_clk = ~csb_clk;

  // APB slave: raise pready after wait_states ACCESS cycles.
  int acc_cnt = 0;
  always @(negedge csb_clk) begin
    if (psel && penable) begin
      pready  = (acc_cnt == wait_states);
      acc_cnt = acc_cnt + 1;
    end else begin
      pready  = 1'b0;
      acc_cnt = 0;
    end
  end

  // Log completed APB transfers and flag SETUP phases with no idle gap before them.
  logic prev_psel = 1'b0;
  always @(posedge csb_clk) begin
    if (psel && penable && pready) begin
      log_addr.push_back(paddr);
      log_wr.push_back(pwrite);
      log_data.push_back(pwdata);
    end
    if (psel && !penable && prev_psel) gap_err = gap_err + 1;
    prev_psel = psel;
  end

  task automatic axi_send(input logic do_aw, input logic do_w, input logic do_ar);
    logic aw_go, w_go, ar_go;
    @(negedge csb_clk);
    s_axil_awvalid = do_aw;
    s_axil_wvalid  = do_w;
    s_axil_arvalid = do_ar;
    for (int i = 0; i < 50 && (s_axil_awvalid || s_axil_wvalid || s_axil_arvalid); i++) begin
      aw_go = s_axil_awvalid && s_axil_awready;
      w_go  = s_axil_wvalid && s_axil_wready;
      ar_go = s_axil_arvalid && s_axil_arready;
      @(posedge csb_clk);
      #1;
      if (aw_go) s_axil_awvalid = 1'b0;
      if (w_go)  s_axil_wvalid  = 1'b0;
      if (ar_go) s_axil_arvalid = 1'b0;
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    s_axil_arvalid = 1'b0;
  endtask

  task automatic wait_valid(input logic is_write, output int cyc);
    cyc = 0;
    do begin
      @(negedge csb_clk);
      cyc++;
    end while (!(is_write ? s_axil_bvalid : s_axil_rvalid) && cyc < 200);
  endtask

  task automatic take_resp();
    s_axil_bready = 1'b1;
    s_axil_rready = 1'b1;
    @(posedge csb_clk);
    #1;
    s_axil_bready = 1'b0;
    s_axil_rready = 1'b0;
  endtask

  task automatic test_reset();
    #3 csb_rstn = 1'b0;
    repeat (2) @(negedge csb_clk);
    vectors++;
    if ({s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid,
         psel, penable, pwrite} !== 8'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 00000000", {s_axil_awready, s_axil_wready,
               s_axil_bvalid, s_axil_arready, s_axil_rvalid, psel, penable, pwrite});
    end
    vectors++;
    if ({paddr, pwdata, s_axil_rdata, s_axil_bresp, s_axil_rresp} !== 100'b0) begin
      miscompares++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h bresp=%b rresp=%b expected all 0",
               paddr, pwdata, s_axil_rdata, s_axil_bresp, s_axil_rresp);
    end
    csb_rstn = 1'b1;
    @(negedge csb_clk);
    vectors++;
    if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b111) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b expected 111",
               {s_axil_awready, s_axil_wready, s_axil_arready});
    end
  endtask

  task automatic test_single_write();
    int n0, lat;
    n0 = log_addr.size();
    wait_states = 0;
    @(negedge csb_clk);
    s_axil_awaddr = 32'h0000_5004;
    s_axil_wdata = 32'h1234_5678;
    s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1;
    s_axil_wvalid = 1'b1;
    vectors++;
    if ({s_axil_awready, s_axil_wready} !== 2'b11) begin
      miscompares++;
      $display("FAIL write_accept: got %b expected 11", {s_axil_awready, s_axil_wready});
    end
    @(posedge csb_clk);
    #1;
    s_axil_awvalid = 1'b0;
    s_axil_wvalid = 1'b0;
    lat = 0;
    do begin
      @(negedge csb_clk);
      lat++;
    end while (!s_axil_bvalid && lat < 20);
    vectors++;
    if (lat !== 3) begin
      miscompares++;
      $display("FAIL write_latency: got %0d expected 3", lat);
    end
    vectors++;
    if (s_axil_bresp !== 2'b00) begin
      miscompares++;
      $display("FAIL write_bresp: got %b expected 00", s_axil_bresp);
    end
    vectors++;
    if (log_addr.size() != n0 + 1) begin
      miscompares++;
      $display("FAIL write_apb_count: got %0d expected %0d", log_addr.size(), n0 + 1);
    end else if ({log_addr[n0], log_wr[n0], log_data[n0]} !== {32'h5004, 1'b1, 32'h1234_5678}) begin
      miscompares++;
      $display("FAIL write_apb: got addr=%h wr=%b data=%h expected 00005004 1 12345678",
               log_addr[n0], log_wr[n0], log_data[n0]);
    end
    take_resp();
    @(negedge csb_clk);
    vectors++;
    if (s_axil_bvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL write_bvalid_clear: got %b expected 0", s_axil_bvalid);
    end
  endtask

  task automatic test_single_read();
    int n0, cyc;
    n0 = log_addr.size();
    wait_states = 2;
    prdata = 32'hCAFE_0001;
    s_axil_araddr = 32'h0000_A000;
    axi_send(1'b0, 1'b0, 1'b1);
    wait_valid(1'b0, cyc);
    vectors++;
    if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata} !== {1'b1, 2'b00, 32'hCAFE_0001}) begin
      miscompares++;
      $display("FAIL read_resp: got rvalid=%b rresp=%b rdata=%h expected 1 00 cafe0001",
               s_axil_rvalid, s_axil_rresp, s_axil_rdata);
    end
    vectors++;
    if (log_addr.size() != n0 + 1) begin
      miscompares++;
      $display("FAIL read_apb_count: got %0d expected %0d", log_addr.size(), n0 + 1);
    end else if ({log_addr[n0], log_wr[n0]} !== {32'hA000, 1'b0}) begin
      miscompares++;
      $display("FAIL read_apb: got addr=%h wr=%b expected 0000a000 0", log_addr[n0], log_wr[n0]);
    end
    take_resp();
  endtask

  task automatic test_contention();
    int n0;
    n0 = log_addr.size();
    wait_states = 0;
    prdata = 32'h0000_0022;
    s_axil_bready = 1'b1;
    s_axil_rready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      s_axil_awaddr = 32'h100 + 32'(r * 4);
      s_axil_araddr = 32'h200 + 32'(r * 4);
      s_axil_wdata = 32'h11 + 32'(r);
      s_axil_wstrb = 4'hF;
      axi_send(1'b1, 1'b1, 1'b1);
      repeat (15) @(negedge csb_clk);
    end
    s_axil_bready = 1'b0;
    s_axil_rready = 1'b0;
    vectors++;
    if (log_addr.size() != n0 + 4) begin
      miscompares++;
      $display("FAIL contention_count: got %0d expected %0d", log_addr.size(), n0 + 4);
    end else if ({log_wr[n0], log_wr[n0+1], log_wr[n0+2], log_wr[n0+3]} !== 4'b1010 ||
                 {log_addr[n0], log_addr[n0+1], log_addr[n0+2], log_addr[n0+3]} !==
                 {32'h100, 32'h200, 32'h104, 32'h204}) begin
      miscompares++;
      $display("FAIL contention_order: got wr=%b%b%b%b addr=%h %h %h %h expected 1010 100 200 104 204",
               log_wr[n0], log_wr[n0+1], log_wr[n0+2], log_wr[n0+3],
               log_addr[n0], log_addr[n0+1], log_addr[n0+2], log_addr[n0+3]);
    end
    vectors++;
    if (gap_err !== 0) begin
      miscompares++;
      $display("FAIL psel_gap: got %0d back-to-back setups expected 0", gap_err);
    end
  endtask

  task automatic test_w_before_aw();
    int n0, cyc;
    n0 = log_addr.size();
    wait_states = 0;
    s_axil_wdata = 32'hAAAA_5555;
    s_axil_wstrb = 4'h3;
    axi_send(1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge csb_clk);
    vectors++;
    if ((log_addr.size() != n0) || (psel !== 1'b0)) begin
      miscompares++;
      $display("FAIL w_only_no_apb: got count=%0d psel=%b expected %0d 0",
               log_addr.size(), psel, n0);
    end
    s_axil_awaddr = 32'h0000_600B;
    axi_send(1'b1, 1'b0, 1'b0);
    wait_valid(1'b1, cyc);
    vectors++;
    if ({s_axil_bvalid, s_axil_bresp} !== {1'b1, 2'b10}) begin
      miscompares++;
      $display("FAIL strb_bresp: got bvalid=%b bresp=%b expected 1 10", s_axil_bvalid, s_axil_bresp);
    end
    vectors++;
    if (log_addr.size() != n0 + 1) begin
      miscompares++;
      $display("FAIL strb_apb_count: got %0d expected %0d", log_addr.size(), n0 + 1);
    end else if ({log_addr[n0], log_wr[n0], log_data[n0]} !== {32'h6008, 1'b1, 32'hAAAA_5555}) begin
      miscompares++;
      $display("FAIL strb_apb: got addr=%h wr=%b data=%h expected 00006008 1 aaaa5555",
               log_addr[n0], log_wr[n0], log_data[n0]);
    end
    take_resp();
  endtask

  task automatic test_timeout();
    int acc, cyc;
    wait_states = 1000;
    s_axil_araddr = 32'h0000_B000;
    axi_send(1'b0, 1'b0, 1'b1);
    acc = 0;
    cyc = 0;
    while (!s_axil_rvalid && cyc < 100) begin
      @(negedge csb_clk);
      cyc++;
      if (penable) acc++;
    end
    vectors++;
    if (acc !== 16) begin
      miscompares++;
      $display("FAIL timeout_access_len: got %0d expected 16", acc);
    end
    vectors++;
    if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata} !== {1'b1, 2'b10, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL timeout_resp: got rvalid=%b rresp=%b rdata=%h expected 1 10 deadbeef",
               s_axil_rvalid, s_axil_rresp, s_axil_rdata);
    end
    take_resp();
    wait_states = 1;
    prdata = 32'h0000_1111;
    s_axil_araddr = 32'h0000_B004;
    axi_send(1'b0, 1'b0, 1'b1);
    wait_valid(1'b0, cyc);
    vectors++;
    if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata} !== {1'b1, 2'b00, 32'h0000_1111}) begin
      miscompares++;
      $display("FAIL after_timeout_read: got rvalid=%b rresp=%b rdata=%h expected 1 00 00001111",
               s_axil_rvalid, s_axil_rresp, s_axil_rdata);
    end
    take_resp();
  endtask

  task automatic test_reset_mid_access();
    int cyc, n0;
    logic stale;
    wait_states = 1000;
    s_axil_awaddr = 32'h0000_7000;
    s_axil_wdata = 32'h0000_0077;
    s_axil_wstrb = 4'hF;
    axi_send(1'b1, 1'b1, 1'b0);
    cyc = 0;
    while (!penable && cyc < 20) begin
      @(negedge csb_clk);
      cyc++;
    end
    @(negedge csb_clk);
    #2 csb_rstn = 1'b0;
    #1;
    vectors++;
    if ({s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid,
         psel, penable, pwrite, paddr, pwdata} !== 72'b0) begin
      miscompares++;
      $display("FAIL async_reset: got flags=%b paddr=%h pwdata=%h expected all 0",
               {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid,
                psel, penable, pwrite}, paddr, pwdata);
    end
    @(negedge csb_clk);
    csb_rstn = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge csb_clk);
      if (s_axil_bvalid || psel) stale = 1'b1;
    end
    vectors++;
    if (stale !== 1'b0) begin
      miscompares++;
      $display("FAIL stale_after_reset: got bvalid/psel activity=%b expected 0", stale);
    end
    n0 = log_addr.size();
    wait_states = 0;
    s_axil_awaddr = 32'h0000_7004;
    s_axil_wdata = 32'h0000_0099;
    axi_send(1'b1, 1'b1, 1'b0);
    wait_valid(1'b1, cyc);
    vectors++;
    if ({s_axil_bvalid, s_axil_bresp} !== {1'b1, 2'b00}) begin
      miscompares++;
      $display("FAIL post_reset_write: got bvalid=%b bresp=%b expected 1 00",
               s_axil_bvalid, s_axil_bresp);
    end
    vectors++;
    if (log_addr.size() != n0 + 1) begin
      miscompares++;
      $display("FAIL post_reset_apb_count: got %0d expected %0d", log_addr.size(), n0 + 1);
    end else if ({log_addr[n0], log_data[n0]} !== {32'h7004, 32'h99}) begin
      miscompares++;
      $display("FAIL post_reset_apb: got addr=%h data=%h expected 00007004 00000099",
               log_addr[n0], log_data[n0]);
    end
    take_resp();
  endtask

  initial begin
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    s_axil_arvalid = 1'b0;
    s_axil_bready  = 1'b0;
    s_axil_rready  = 1'b0;
    s_axil_awaddr  = '0;
    s_axil_araddr  = '0;
    s_axil_wdata   = '0;
    s_axil_wstrb   = 4'hF;
    prdata         = '0;
    pslverr        = 1'b0;
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_w_before_aw();
    test_timeout();
    test_reset_mid_access();
    repeat (3) @(negedge csb_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
